// File: rtl/snitch_mem_arbiter.sv
// snitch_mem_arbiter: shares one 64-bit memory port between Snitch fetch
// and data ports; round-robin, one access in flight, 1-entry response buffer.
module snitch_mem_arbiter #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] inst_addr_i,
  input  logic                 inst_valid_i,
  output logic                 inst_ready_o,
  output logic [31:0]          inst_data_o,
  input  logic [AddrWidth-1:0] data_qaddr_i,
  input  logic                 data_qwrite_i,
  input  logic [DataWidth-1:0] data_qdata_i,
  input  logic [7:0]           data_qstrb_i,
  input  logic                 data_qvalid_i,
  output logic                 data_qready_o,
  output logic [DataWidth-1:0] data_pdata_o,
  output logic                 data_perror_o,
  output logic                 data_pvalid_o,
  input  logic                 data_pready_i,
  output logic                 mem_valid_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_write_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [7:0]           mem_wstrb_o,
  input  logic                 mem_ready_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic [CntWidth-1:0]  conflict_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    INST,
    DATA
  } state_e;

  state_e               state_q, state_d;
  logic                 last_data_q, last_data_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [7:0]           strb_q, strb_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;

  logic is_idle;
  logic data_elig;
  logic grant_data;
  logic grant_inst;
  logic fill;

  assign is_idle   = (state_q == IDLE);
  // A data request may only go out if its response has somewhere to land.
  assign data_elig = data_qvalid_i & (~rsp_valid_q | data_pready_i);
  assign grant_data = data_elig & (~inst_valid_i | ~last_data_q);
  assign grant_inst = inst_valid_i & ~grant_data;
  assign fill       = (state_q == DATA) & mem_ready_i;

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant_data: begin
            state_d     = DATA;
            last_data_d = 1'b1;
            addr_d      = data_qaddr_i;
            write_d     = data_qwrite_i;
            wdata_d     = data_qdata_i;
            strb_d      = data_qstrb_i;
          end
          grant_inst: begin
            state_d     = INST;
            last_data_d = 1'b0;
            addr_d      = inst_addr_i;
            write_d     = 1'b0;
            wdata_d     = '0;
            strb_d      = '0;
          end
          default: ;
        endcase
        if (inst_valid_i && data_qvalid_i && cnt_q != '1) begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      INST: if (mem_ready_i) state_d = IDLE;
      DATA: if (mem_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A fill in the same cycle as a consume keeps the buffer occupied.
  always_comb begin
    rsp_valid_d = fill | (rsp_valid_q & ~data_pready_i);
    rsp_data_d  = fill ? mem_rdata_i : rsp_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      last_data_q <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_valid_o    = ~is_idle;
  assign mem_addr_o     = addr_q;
  assign mem_write_o    = write_q;
  assign mem_wdata_o    = wdata_q;
  assign mem_wstrb_o    = strb_q;
  assign data_qready_o  = rst_ni & is_idle & grant_data;
  assign data_pvalid_o  = rsp_valid_q;
  assign data_pdata_o   = rsp_data_q;
  assign data_perror_o  = 1'b0;
  assign conflict_cnt_o = cnt_q;
  assign inst_ready_o   = (state_q == INST) & mem_ready_i & inst_valid_i;
  assign inst_data_o    = (state_q != INST) ? 32'h0 :
                          addr_q[2] ? mem_rdata_i[63:32] :
                          mem_rdata_i[31:0];

endmodule

// File: tb/tb_snitch_mem_arbiter.sv
// Bench for snitch_mem_arbiter: behavioural memory plus reference memory;
// expectations go into per-port queues popped by an independent monitor.
module tb_snitch_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic        inst_valid_i = 1'b0;
  logic        inst_ready_o;
  logic [31:0] inst_data_o;
  logic [31:0] data_qaddr_i = '0;
  logic        data_qwrite_i = 1'b0;
  logic [63:0] data_qdata_i = '0;
  logic [7:0]  data_qstrb_i = '0;
  logic        data_qvalid_i = 1'b0;
  logic        data_qready_o;
  logic [63:0] data_pdata_o;
  logic        data_perror_o;
  logic        data_pvalid_o;
  logic        data_pready_i = 1'b0;
  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic        mem_write_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_ready_i = 1'b0;
  logic [63:0] mem_rdata_i = '0;
  logic [15:0] conflict_cnt_o;

  // second instance with a narrow counter to reach saturation quickly
  logic        s_inst_ready, s_qready, s_perror, s_pvalid;
  logic        s_mvalid, s_mwrite;
  logic [31:0] s_inst_data, s_maddr;
  logic [63:0] s_pdata, s_mwdata;
  logic [7:0]  s_mwstrb;
  logic [5:0]  s_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int mem_mode = 1;
  int prd_mode = 1;
  int unsigned cnt_model = 0;

  logic [31:0] iq[$];
  logic [63:0] dq[$];
  logic [63:0] mem[logic [31:0]];
  logic [63:0] ref_mem[logic [31:0]];

  snitch_mem_arbiter u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .inst_addr_i(inst_addr_i), .inst_valid_i(inst_valid_i),
    .inst_ready_o(inst_ready_o), .inst_data_o(inst_data_o),
    .data_qaddr_i(data_qaddr_i), .data_qwrite_i(data_qwrite_i),
    .data_qdata_i(data_qdata_i), .data_qstrb_i(data_qstrb_i),
    .data_qvalid_i(data_qvalid_i), .data_qready_o(data_qready_o),
    .data_pdata_o(data_pdata_o), .data_perror_o(data_perror_o),
    .data_pvalid_o(data_pvalid_o), .data_pready_i(data_pready_i),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
    .mem_write_o(mem_write_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .conflict_cnt_o(conflict_cnt_o)
  );

  snitch_mem_arbiter #(.CntWidth(6)) u_sat (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .inst_addr_i(inst_addr_i), .inst_valid_i(inst_valid_i),
    .inst_ready_o(s_inst_ready), .inst_data_o(s_inst_data),
    .data_qaddr_i(data_qaddr_i), .data_qwrite_i(data_qwrite_i),
    .data_qdata_i(data_qdata_i), .data_qstrb_i(data_qstrb_i),
    .data_qvalid_i(data_qvalid_i), .data_qready_o(s_qready),
    .data_pdata_o(s_pdata), .data_perror_o(s_perror),
    .data_pvalid_o(s_pvalid), .data_pready_i(data_pready_i),
    .mem_valid_o(s_mvalid), .mem_addr_o(s_maddr),
    .mem_write_o(s_mwrite), .mem_wdata_o(s_mwdata),
    .mem_wstrb_o(s_mwstrb), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .conflict_cnt_o(s_cnt)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] wkey(logic [31:0] a);
    return {a[31:3], 3'b000};
  endfunction

  function automatic logic [63:0] init_word(logic [31:0] k);
    return {k ^ 32'h5A5A_0000, ~k};
  endfunction

  function automatic logic [63:0] merge(logic [63:0] o, logic [63:0] w,
                                        logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mem_rd(logic [31:0] a);
    logic [31:0] k;
    k = wkey(a);
    return mem.exists(k) ? mem[k] : init_word(k);
  endfunction

  function automatic logic [63:0] ref_rd(logic [31:0] a);
    logic [31:0] k;
    k = wkey(a);
    return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_inst_ready"}, inst_ready_o, 0);
    chk({tag, "_inst_data"}, inst_data_o, 0);
    chk({tag, "_qready"}, data_qready_o, 0);
    chk({tag, "_pvalid"}, data_pvalid_o, 0);
    chk({tag, "_pdata"}, data_pdata_o, 0);
    chk({tag, "_perror"}, data_perror_o, 0);
    chk({tag, "_mem_valid"}, mem_valid_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_write"}, mem_write_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb_o, 0);
    chk({tag, "_cnt"}, conflict_cnt_o, 0);
  endtask

  // memory model: random or forced wait states, read returns the old word
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      case (mem_mode)
        0: mem_ready_i = ($urandom_range(0, 3) != 0);
        1: mem_ready_i = 1'b1;
        default: mem_ready_i = 1'b0;
      endcase
      case (prd_mode)
        0: data_pready_i = 1'($urandom_range(0, 1));
        1: data_pready_i = 1'b1;
        default: data_pready_i = 1'b0;
      endcase
      mem_rdata_i = mem_valid_o ? mem_rd(mem_addr_o) : 64'h0;
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && mem_valid_o && mem_ready_i && mem_write_o)
        mem[wkey(mem_addr_o)] = merge(mem_rd(mem_addr_o), mem_wdata_o,
                                      mem_wstrb_o);
    end
  end

  // monitor
  initial begin
    logic        stall;
    logic [41:0] p_ctl;
    logic [63:0] p_wd;
    logic [63:0] cexp;
    stall = 1'b0;
    p_ctl = '0;
    p_wd  = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        stall = 1'b0;
        cnt_model = 0;
      end else begin
        if (inst_ready_o) begin
          if (iq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL inst_unexpected: got %h expected none", inst_data_o);
          end else chk("inst_data", inst_data_o, iq.pop_front());
        end
        if (data_pvalid_o && data_pready_i) begin
          if (dq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL data_unexpected: got %h expected none", data_pdata_o);
          end else chk("data_rsp", data_pdata_o, dq.pop_front());
        end
        if (inst_ready_o && data_qready_o) fail_now("ready_overlap");
        if (stall) begin
          chk("mem_hold_ctl",
              {mem_valid_o, mem_write_o, mem_wstrb_o, mem_addr_o}, p_ctl);
          chk("mem_hold_wdata", mem_wdata_o, p_wd);
        end
        cexp = (cnt_model > 65535) ? 65535 : cnt_model;
        chk("conflict_cnt", conflict_cnt_o, cexp);
        cexp = (cnt_model > 63) ? 63 : cnt_model;
        chk("conflict_sat", s_cnt, cexp);
        if (!mem_valid_o && inst_valid_i && data_qvalid_i) cnt_model++;
        stall = mem_valid_o && !mem_ready_i;
        p_ctl = {mem_valid_o, mem_write_o, mem_wstrb_o, mem_addr_o};
        p_wd  = mem_wdata_o;
      end
    end
  end

  task automatic data_req(input logic [31:0] a, input logic w,
                          input logic [63:0] wd, input logic [7:0] st,
                          input bit track);
    int t;
    logic [63:0] e;
    t = 0;
    @(posedge clk_i);
    #1;
    data_qaddr_i  = a;
    data_qwrite_i = w;
    data_qdata_i  = wd;
    data_qstrb_i  = st;
    data_qvalid_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (data_qready_o) break;
      if (++t > 300) begin
        fail_now("data_req_wait");
        break;
      end
    end
    if (data_qready_o && track) begin
      e = ref_rd(a);
      dq.push_back(e);
      if (w) ref_mem[wkey(a)] = merge(e, wd, st);
    end
    @(posedge clk_i);
    #1;
    data_qvalid_i = 1'b0;
  endtask

  task automatic inst_req(input logic [31:0] a);
    int t;
    logic [63:0] w;
    t = 0;
    @(posedge clk_i);
    #1;
    w = ref_rd(a);
    iq.push_back(a[2] ? w[63:32] : w[31:0]);
    inst_addr_i  = a;
    inst_valid_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (inst_ready_o) break;
      if (++t > 300) begin
        fail_now("inst_req_wait");
        break;
      end
    end
    @(posedge clk_i);
    #1;
    inst_valid_i = 1'b0;
  endtask

  // both sides held valid from a fresh reset: winners alternate, data first
  task automatic alt_run(input int n);
    logic [63:0] w;
    bit want_data;
    int g;
    want_data = 1'b1;
    g = 0;
    mem_mode = 1;
    prd_mode = 1;
    @(posedge clk_i);
    #1;
    data_qaddr_i  = 32'h2040;
    data_qwrite_i = 1'b0;
    data_qdata_i  = '0;
    data_qstrb_i  = '0;
    data_qvalid_i = 1'b1;
    inst_addr_i   = 32'h1010;
    inst_valid_i  = 1'b1;
    for (int c = 0; c < 4 * n && g < n; c++) begin
      @(negedge clk_i);
      if (!mem_valid_o) begin
        chk("alt_grant_data", data_qready_o, want_data);
        w = ref_rd(want_data ? 32'h2040 : 32'h1010);
        if (want_data) dq.push_back(w);
        else iq.push_back(w[31:0]);
        want_data = !want_data;
        g++;
      end
    end
    chk("alt_grants", g, n);
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    data_qvalid_i = 1'b0;
    inst_valid_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    int t;
    #3;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    alt_run(8);

    // fetch latency and word-half selection
    mem[wkey(32'h0001_0000)] = 64'hAAAA_BBBB_CCCC_DDDD;
    ref_mem[wkey(32'h0001_0000)] = 64'hAAAA_BBBB_CCCC_DDDD;
    @(posedge clk_i);
    #1;
    iq.push_back(32'hAAAA_BBBB);
    inst_addr_i  = 32'h0001_0004;
    inst_valid_i = 1'b1;
    @(negedge clk_i);
    chk("fetch_n_mem_valid", mem_valid_o, 0);
    @(negedge clk_i);
    chk("fetch_n1_mem_valid", mem_valid_o, 1);
    chk("fetch_n1_ready", inst_ready_o, 1);
    @(posedge clk_i);
    #1;
    inst_valid_i = 1'b0;
    inst_req(32'h0001_0000);
    chk("fetch_lo_expected", iq.size(), 0);

    // write with three wait states
    mem_mode = 2;
    data_req(32'h100, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("wr_mem_valid", mem_valid_o, 1);
      chk("wr_mem_addr", mem_addr_o, 32'h100);
      chk("wr_mem_write", mem_write_o, 1);
      chk("wr_mem_wdata", mem_wdata_o, 64'h1122_3344_5566_7788);
      chk("wr_mem_wstrb", mem_wstrb_o, 8'hFF);
      if (c == 2) mem_mode = 1;
    end
    @(negedge clk_i);
    chk("wr_rsp_valid", data_pvalid_o, 1);
    data_req(32'h100, 1'b0, 64'h0, 8'h0, 1);
    repeat (3) @(negedge clk_i);
    chk("wr_readback_done", dq.size(), 0);

    // full response buffer blocks data, fetch still served
    prd_mode = 2;
    data_req(32'h2008, 1'b0, 64'h0, 8'h0, 1);
    repeat (2) @(negedge clk_i);
    chk("hold_rsp_valid", data_pvalid_o, 1);
    @(posedge clk_i);
    #1;
    data_qaddr_i  = 32'h2010;
    data_qwrite_i = 1'b0;
    data_qvalid_i = 1'b1;
    w = ref_rd(32'h1020);
    iq.push_back(w[31:0]);
    inst_addr_i  = 32'h1020;
    inst_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("hold_qready_blocked", data_qready_o, 0);
      if (c == 1) begin
        chk("hold_fetch_served", inst_ready_o, 1);
        @(posedge clk_i);
        #1;
        inst_valid_i = 1'b0;
      end
    end
    prd_mode = 1;
    @(negedge clk_i);
    chk("hold_qready_release", data_qready_o, 1);
    if (data_qready_o) dq.push_back(ref_rd(32'h2010));
    @(posedge clk_i);
    #1;
    data_qvalid_i = 1'b0;

    // randomised traffic on both ports
    mem_mode = 0;
    prd_mode = 0;
    fork
      for (int i = 0; i < 60; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk_i);
        data_req(32'h2000 + 8 * $urandom_range(0, 15),
                 1'($urandom_range(0, 1)), {$urandom, $urandom},
                 8'($urandom_range(0, 255)), 1);
      end
      for (int i = 0; i < 60; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk_i);
        inst_req(32'h1000 + 4 * $urandom_range(0, 63));
      end
    join
    mem_mode = 1;
    prd_mode = 1;
    t = 0;
    while ((iq.size() != 0 || dq.size() != 0) && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    chk("drain_queues", iq.size() + dq.size(), 0);

    // reset in the middle of a data wait
    @(posedge clk_i);
    #1;
    mem_mode = 2;
    data_req(32'h2018, 1'b0, 64'h0, 8'h0, 0);
    repeat (2) @(negedge clk_i);
    chk("rst_in_wait", mem_valid_o, 1);
    #2;
    rst_ni = 1'b0;
    data_qvalid_i = 1'b1;
    inst_valid_i  = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk_i);
    #1;
    data_qvalid_i = 1'b0;
    inst_valid_i  = 1'b0;
    mem_mode = 1;
    rst_ni = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("post_rst_no_rsp", data_pvalid_o, 0);
    end

    alt_run(80);
    @(negedge clk_i);
    chk("sat_final", s_cnt, 63);
    chk("cnt_final", conflict_cnt_o, 80);
    repeat (3) @(negedge clk_i);
    chk("final_queues", iq.size() + dq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
